taxi_eth_phy_baser_rx_lock_ml: RTL and testbench
================================================

// Module: taxi_eth_phy_baser_rx_lock_ml
// PURPOSE
// - Multi-lane 64b/66b block-lock + BER monitor; generalises single-lane 10G RX framer/lock to LANES independent lanes.
// - Sits between SERDES RX (sync headers) and the BASE-R decoder/MAC; drives per-lane bitslip, lock, high-BER, reset request.
// - Thresholds, slip timing and BER window are parameters, so one block serves 10G/25G/40G-multilane.
// PARAMETERS
// - LANES               1       number of independent lanes
// - LOCK_CNT            64      consecutive valid headers needed to gain lock
// - UNLOCK_INVLD        16      invalid headers within a LOCK_CNT window that drop lock
// - BER_INVLD           16      invalid headers within one BER window that set high-BER
// - COUNT_125US         19531   clk cycles per BER window (125 us)
// - BITSLIP_HIGH_CYCLES 0       extra cycles bitslip held high (pulse = 1+N cycles)
// - BITSLIP_LOW_CYCLES  7       cycles headers ignored after slip pulse
// - RST_TIMEOUT_WIN     8       BER windows without lock before reset request
// PORTS
// - clk                  in   1           clock
// - rst                  in   1           synchronous active-high reset
// - serdes_rx_hdr        in   2*LANES     sync header per lane, lane n at [2n+:2]
// - serdes_rx_hdr_valid  in   LANES       header valid qualifier per lane
// - serdes_rx_bitslip    out  LANES       bitslip request per lane
// - serdes_rx_reset_req  out  LANES       1-cycle SERDES reset request per lane
// - rx_block_lock        out  LANES       lane block lock
// - rx_high_ber          out  LANES       lane high BER
// - rx_all_lock          out  1           AND of rx_block_lock
// BEHAVIOUR
// - Reset: all outputs 0; per-lane FSM=SEARCH; all counters 0.
// - Header valid iff hdr_valid && hdr in {2'b01,2'b10}; invalid iff hdr_valid && hdr in {00,11}; hdr_valid=0 -> not counted.
// - Per-lane FSM (lanes fully independent):
//   SEARCH: valid -> sh_cnt++; sh_cnt reaches LOCK_CNT -> LOCKED, lock=1 next cycle, counts cleared. Invalid -> SLIP.
//   LOCKED: window of LOCK_CNT counted headers; invalid -> invld_cnt++; invld_cnt reaches UNLOCK_INVLD -> lock=0, SLIP.
//     Window end with invld_cnt<UNLOCK_INVLD -> clear both counts, stay. Invalid on last header of window counts toward that window.
//   SLIP: bitslip=1 for 1+BITSLIP_HIGH_CYCLES cycles, then HOLD.
//   HOLD: headers ignored BITSLIP_LOW_CYCLES cycles (0 -> direct), then SEARCH with counts 0.
// - Lock set/clear is registered: 1-cycle latency from deciding header.
// - BER: shared free-running window counter 0..COUNT_125US-1, wraps; per-lane ber_cnt counts invalid headers (all FSM states except HOLD),
//   saturates at BER_INVLD; reaching BER_INVLD -> high_ber=1 immediately next cycle; at wrap, high_ber=(ber_cnt>=BER_INVLD) of closing window, ber_cnt=0.
//   Invalid header on the wrap cycle counts into the new window.
// - Reset request: per-lane nolock_cnt increments at each window wrap while lock=0, clears when lock=1; reaching RST_TIMEOUT_WIN ->
//   reset_req pulses 1 cycle, nolock_cnt=0, FSM forced to SEARCH. RST_TIMEOUT_WIN=0 disables.
// - rst mid-slip: bitslip drops next cycle; no partial pulse resumes.
// CONFIGURATION
// - TAXI_ETH_RX_LOCK_STATS_EN defined: adds out ports stat_rx_bitslip[LANES] and stat_rx_lock_loss[LANES], each a 1-cycle pulse
//   per slip start / LOCKED->not-locked event, plus out stat_rx_slip_cnt[16*LANES], per-lane saturating slip counters (reset 0).
// - Undefined: those ports and counters do not exist; core behaviour identical.
// TESTING
// - LANES=2, lane0 64 valid hdrs (2'b01) -> rx_block_lock[0]=1 cycle after 64th; lane1 held 2'b00 -> bitslip[1] pulses repeatedly.
// - Locked lane, 15 invalid in 64-window -> lock stays 1; 16 invalid in next window -> lock=0, bitslip 1 cycle, then 7 ignored cycles.
// - BITSLIP_HIGH_CYCLES=2, invalid in SEARCH -> bitslip high exactly 3 cycles; hdrs during HOLD do not advance sh_cnt.
// - COUNT_125US=100, 16 invalid within window -> high_ber=1; next window 0 invalid -> high_ber=0 at wrap.
// - RST_TIMEOUT_WIN=2, COUNT_125US=100, no lock -> reset_req 1-cycle pulse at 2nd wrap; rst asserted mid-SLIP -> all outputs 0 next cycle.
// - STATS_EN build: 3 forced slips -> stat_rx_slip_cnt lane = 3; lock loss -> one stat_rx_lock_loss pulse.

Source files
------------

// File: rtl/taxi_eth_phy_baser_rx_lock_ml_if.sv
// rtl/taxi_eth_phy_baser_rx_lock_ml_if.sv - SERDES RX header/bitslip/reset bundle for the multi-lane block-lock monitor
interface taxi_eth_phy_baser_rx_lock_ml_if #(
    parameter int LANES = 1
);
    logic [2*LANES-1:0] serdes_rx_hdr;
    logic [LANES-1:0]   serdes_rx_hdr_valid;
    logic [LANES-1:0]   serdes_rx_bitslip;
    logic [LANES-1:0]   serdes_rx_reset_req;

    modport master (
        output serdes_rx_hdr,
        output serdes_rx_hdr_valid,
        input  serdes_rx_bitslip,
        input  serdes_rx_reset_req
    );

    modport slave (
        input  serdes_rx_hdr,
        input  serdes_rx_hdr_valid,
        output serdes_rx_bitslip,
        output serdes_rx_reset_req
    );
endinterface

// File: rtl/taxi_eth_phy_baser_rx_lock_ml.sv
// rtl/taxi_eth_phy_baser_rx_lock_ml.sv - Multi-lane 64b/66b block lock, high-BER and reset-request monitor (option macro: TAXI_ETH_RX_LOCK_STATS_EN)
module taxi_eth_phy_baser_rx_lock_ml #(
    parameter int LANES               = 1,
    parameter int LOCK_CNT            = 64,
    parameter int UNLOCK_INVLD        = 16,
    parameter int BER_INVLD           = 16,
    parameter int COUNT_125US         = 19531,
    parameter int BITSLIP_HIGH_CYCLES = 0,
    parameter int BITSLIP_LOW_CYCLES  = 7,
    parameter int RST_TIMEOUT_WIN     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    taxi_eth_phy_baser_rx_lock_ml_if.slave     serdes,
    output logic [LANES-1:0]                   rx_block_lock,
    output logic [LANES-1:0]                   rx_high_ber,
`ifdef TAXI_ETH_RX_LOCK_STATS_EN
    output logic [LANES-1:0]                   stat_rx_bitslip,
    output logic [LANES-1:0]                   stat_rx_lock_loss,
    output logic [16*LANES-1:0]                stat_rx_slip_cnt,
`endif
    output logic                               rx_all_lock
);

    localparam int SH_W    = $clog2(LOCK_CNT + 1);
    localparam int IV_W    = $clog2(UNLOCK_INVLD + 1);
    localparam int BER_W   = $clog2(BER_INVLD + 1);
    localparam int WIN_W   = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
    localparam int NL_W    = $clog2(RST_TIMEOUT_WIN + 2);
    localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ? BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 2);

    localparam logic [SH_W-1:0]  LOCK_V    = SH_W'(LOCK_CNT);
    localparam logic [IV_W-1:0]  UNLOCK_V  = IV_W'(UNLOCK_INVLD);
    localparam logic [BER_W-1:0] BER_V     = BER_W'(BER_INVLD);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(COUNT_125US - 1);
    localparam logic [NL_W-1:0]  NL_V      = NL_W'(RST_TIMEOUT_WIN);
    localparam logic [TMR_W-1:0] SLIP_LAST = TMR_W'(BITSLIP_HIGH_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

    typedef enum logic [1:0] {SEARCH, LOCKED, SLIP, HOLD} state_t;

    logic [WIN_W-1:0] win_cnt;
    logic             wrap;
    logic [LANES-1:0] bitslip_v;
    logic [LANES-1:0] reset_req_v;

    assign wrap = (win_cnt == WIN_LAST);

    // Free-running BER window shared by every lane
    always_ff @(posedge clk) begin
        if (rst || wrap) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t            state_q, state_d;
        logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
        logic [IV_W-1:0]   invld_cnt_q, invld_cnt_d;
        logic [TMR_W-1:0]  tmr_q, tmr_d;
        logic [BER_W-1:0]  ber_cnt_q;
        logic              high_ber_q;
        logic [NL_W-1:0]   nolock_cnt_q;
        logic              reset_req_q;
        logic [1:0]        hdr;
        logic              hdr_vld, hdr_ok, hdr_bad, ber_inc, timeout;
        logic              lock_o, slip_o;

        assign hdr     = serdes.serdes_rx_hdr[2*i +: 2];
        assign hdr_vld = serdes.serdes_rx_hdr_valid[i];
        assign hdr_ok  = hdr_vld && (hdr[1] != hdr[0]);
        assign hdr_bad = hdr_vld && (hdr[1] == hdr[0]);
        // HOLD is the settling time after a slip, so its headers are not evidence of BER
        assign ber_inc = hdr_bad && (state_q != HOLD);
        assign timeout = (RST_TIMEOUT_WIN != 0) && wrap && (state_q != LOCKED) && ((nolock_cnt_q + 1'b1) == NL_V);

        // Lane FSM state and alignment counters
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= SEARCH;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
                tmr_q       <= '0;
            end else begin
                state_q     <= state_d;
                sh_cnt_q    <= sh_cnt_d;
                invld_cnt_q <= invld_cnt_d;
                tmr_q       <= tmr_d;
            end
        end

        // Lane next-state: search for LOCK_CNT good headers, police invalids per window, slip then settle
        always_comb begin
            state_d     = state_q;
            sh_cnt_d    = sh_cnt_q;
            invld_cnt_d = invld_cnt_q;
            tmr_d       = tmr_q;
            case (state_q)
                SEARCH: begin
                    if (hdr_bad) begin
                        state_d  = SLIP;
                        sh_cnt_d = '0;
                        tmr_d    = '0;
                    end else if (hdr_ok) begin
                        if ((sh_cnt_q + 1'b1) == LOCK_V) begin
                            state_d  = LOCKED;
                            sh_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (hdr_vld) begin
                        if (hdr_bad && ((invld_cnt_q + 1'b1) == UNLOCK_V)) begin
                            state_d     = SLIP;
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                            tmr_d       = '0;
                        end else if ((sh_cnt_q + 1'b1) == LOCK_V) begin
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_q + 1'b1;
                            if (hdr_bad) begin
                                invld_cnt_d = invld_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                SLIP: begin
                    if (tmr_q == SLIP_LAST) begin
                        state_d = (BITSLIP_LOW_CYCLES == 0) ? SEARCH : HOLD;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d = SEARCH;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            endcase
            if (timeout) begin
                state_d     = SEARCH;
                sh_cnt_d    = '0;
                invld_cnt_d = '0;
                tmr_d       = '0;
            end
        end

        // Lane outputs decoded from the registered state
        always_comb begin
            lock_o = (state_q == LOCKED);
            slip_o = (state_q == SLIP);
        end

        // Per-window invalid count; high BER rises on reaching the limit, re-evaluated at each wrap
        always_ff @(posedge clk) begin
            if (rst) begin
                ber_cnt_q  <= '0;
                high_ber_q <= 1'b0;
            end else if (wrap) begin
                high_ber_q <= (ber_cnt_q >= BER_V);
                ber_cnt_q  <= BER_W'(ber_inc);
            end else if (ber_inc && (ber_cnt_q != BER_V)) begin
                ber_cnt_q <= ber_cnt_q + 1'b1;
                if ((ber_cnt_q + 1'b1) == BER_V) begin
                    high_ber_q <= 1'b1;
                end
            end
        end

        // Windows without lock; a timeout pulses the SERDES reset request
        always_ff @(posedge clk) begin
            if (rst) begin
                nolock_cnt_q <= '0;
                reset_req_q  <= 1'b0;
            end else begin
                reset_req_q <= timeout;
                if (state_q == LOCKED || timeout) begin
                    nolock_cnt_q <= '0;
                end else if (wrap && RST_TIMEOUT_WIN != 0) begin
                    nolock_cnt_q <= nolock_cnt_q + 1'b1;
                end
            end
        end

        assign rx_block_lock[i] = lock_o;
        assign rx_high_ber[i]   = high_ber_q;
        assign bitslip_v[i]     = slip_o;
        assign reset_req_v[i]   = reset_req_q;

`ifdef TAXI_ETH_RX_LOCK_STATS_EN
        logic        lock_loss_q;
        logic [15:0] slip_cnt_q;

        // Lock-loss pulse and saturating count of slips started
        always_ff @(posedge clk) begin
            if (rst) begin
                lock_loss_q <= 1'b0;
                slip_cnt_q  <= '0;
            end else begin
                lock_loss_q <= (state_q == LOCKED) && (state_d != LOCKED);
                if ((state_d == SLIP) && (state_q != SLIP) && (slip_cnt_q != 16'hffff)) begin
                    slip_cnt_q <= slip_cnt_q + 1'b1;
                end
            end
        end

        assign stat_rx_bitslip[i]         = slip_o && (tmr_q == '0);
        assign stat_rx_lock_loss[i]       = lock_loss_q;
        assign stat_rx_slip_cnt[16*i +: 16] = slip_cnt_q;
`endif
    end

    assign serdes.serdes_rx_bitslip   = bitslip_v;
    assign serdes.serdes_rx_reset_req = reset_req_v;
    assign rx_all_lock                = &rx_block_lock;

endmodule

// File: tb/tb_taxi_eth_phy_baser_rx_lock_ml.sv
// tb/tb_taxi_eth_phy_baser_rx_lock_ml.sv - Directed scoreboard bench for the multi-lane block-lock monitor
module tb_taxi_eth_phy_baser_rx_lock_ml;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    taxi_eth_phy_baser_rx_lock_ml_if #(.LANES(2)) if_a ();
    taxi_eth_phy_baser_rx_lock_ml_if #(.LANES(1)) if_b ();

    logic [1:0] lock_a, ber_a;
    logic       all_a;
    logic [0:0] lock_b, ber_b;
    logic       all_b;

`ifdef TAXI_ETH_RX_LOCK_STATS_EN
    logic [1:0]  sbs_a, sll_a;
    logic [31:0] scnt_a;
    logic [0:0]  sbs_b, sll_b;
    logic [15:0] scnt_b;
    int          ll_cnt_a0 = 0;
    always @(negedge clk) if (sll_a[0]) ll_cnt_a0++;
`endif

    taxi_eth_phy_baser_rx_lock_ml #(
        .LANES(2), .LOCK_CNT(64), .UNLOCK_INVLD(16), .BER_INVLD(16), .COUNT_125US(50000),
        .BITSLIP_HIGH_CYCLES(0), .BITSLIP_LOW_CYCLES(7), .RST_TIMEOUT_WIN(8)
    ) dut_a (
        .clk(clk), .rst(rst), .serdes(if_a),
        .rx_block_lock(lock_a), .rx_high_ber(ber_a),
`ifdef TAXI_ETH_RX_LOCK_STATS_EN
        .stat_rx_bitslip(sbs_a), .stat_rx_lock_loss(sll_a), .stat_rx_slip_cnt(scnt_a),
`endif
        .rx_all_lock(all_a)
    );

    taxi_eth_phy_baser_rx_lock_ml #(
        .LANES(1), .LOCK_CNT(8), .UNLOCK_INVLD(32), .BER_INVLD(16), .COUNT_125US(100),
        .BITSLIP_HIGH_CYCLES(2), .BITSLIP_LOW_CYCLES(7), .RST_TIMEOUT_WIN(2)
    ) dut_b (
        .clk(clk), .rst(rst), .serdes(if_b),
        .rx_block_lock(lock_b), .rx_high_ber(ber_b),
`ifdef TAXI_ETH_RX_LOCK_STATS_EN
        .stat_rx_bitslip(sbs_b), .stat_rx_lock_loss(sll_b), .stat_rx_slip_cnt(scnt_b),
`endif
        .rx_all_lock(all_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   nslip;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic [1:0] h0, input logic [1:0] h1, input logic [1:0] v);
        if_a.serdes_rx_hdr       = {h1, h0};
        if_a.serdes_rx_hdr_valid = v;
    endtask

    initial begin
        drv_a(2'b00, 2'b00, 2'b00);
        if_b.serdes_rx_hdr       = 2'b00;
        if_b.serdes_rx_hdr_valid = 1'b0;
        tick();
        tick();

        push("a_reset_outputs", 32'd0);
        pop_check({lock_a, ber_a, if_a.serdes_rx_bitslip, if_a.serdes_rx_reset_req, all_a});
        push("b_reset_outputs", 32'd0);
        pop_check({lock_b, ber_b, if_b.serdes_rx_bitslip, if_b.serdes_rx_reset_req, all_b});
        rst = 1'b0;

        // lane0 gains lock on the 64th good header; lane1 stuck on 2'b00 slips every 9 cycles
        push("a_lock0_after_63", 32'd0);
        push("a_lock0_after_64", 32'd1);
        push("a_lane1_slip_pulses", 32'd8);
        push("a_all_lock_lane1_down", 32'd0);
        drv_a(2'b01, 2'b00, 2'b11);
        nslip = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (if_a.serdes_rx_bitslip[1]) nslip++;
            if (k == 63) pop_check(lock_a[0]);
            if (k == 64) pop_check(lock_a[0]);
        end
        pop_check(nslip);
        pop_check(all_a);

        // window with 15 invalid (ending on the last header) keeps lock
        push("a_lock0_after_15_invalid", 32'd1);
        push("a_high_ber0_at_15", 32'd0);
        for (int k = 1; k <= 64; k++) begin
            drv_a((k <= 49) ? 2'b01 : 2'b11, 2'b00, 2'b11);
            tick();
        end
        pop_check(lock_a[0]);
        pop_check(ber_a[0]);

        // next window: 16th BER invalid sets high_ber at once, 16th window invalid drops lock
        push("a_high_ber0_at_16", 32'd1);
        push("a_lock0_after_15_of_16", 32'd1);
        push("a_lock0_after_16_of_16", 32'd0);
        push("a_bitslip0_on_unlock", 32'd1);
        drv_a(2'b00, 2'b00, 2'b11);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) pop_check(ber_a[0]);
            if (k == 15) pop_check(lock_a[0]);
            if (k == 16) begin
                pop_check(lock_a[0]);
                pop_check(if_a.serdes_rx_bitslip[0]);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            push($sformatf("a_bitslip0_hold_%0d", k), (k == 9) ? 32'd1 : 32'd0);
            tick();
            pop_check(if_a.serdes_rx_bitslip[0]);
        end
`ifdef TAXI_ETH_RX_LOCK_STATS_EN
        push("a_stat_slip_cnt0", 32'd2);
        pop_check(scnt_a[15:0]);
        push("a_stat_lock_loss0_pulses", 32'd1);
        pop_check(ll_cnt_a0);
`endif

        // dut_b: 3-cycle bitslip, headers during HOLD do not count toward lock
        rst = 1'b1;
        drv_a(2'b00, 2'b00, 2'b00);
        tick();
        rst = 1'b0;
        push("b_bitslip_t1", 32'd1);
        push("b_bitslip_t2", 32'd1);
        push("b_bitslip_t3", 32'd1);
        push("b_bitslip_t4", 32'd0);
        if_b.serdes_rx_hdr       = 2'b11;
        if_b.serdes_rx_hdr_valid = 1'b1;
        tick();
        pop_check(if_b.serdes_rx_bitslip);
        if_b.serdes_rx_hdr = 2'b01;
        for (int t = 2; t <= 4; t++) begin
            tick();
            pop_check(if_b.serdes_rx_bitslip);
        end
        push("b_lock_t18", 32'd0);
        push("b_lock_t19", 32'd1);
        push("b_all_lock_t19", 32'd1);
        for (int t = 5; t <= 19; t++) begin
            tick();
            if (t == 18) pop_check(lock_b);
            if (t == 19) begin
                pop_check(lock_b);
                pop_check(all_b);
            end
        end
`ifdef TAXI_ETH_RX_LOCK_STATS_EN
        push("b_stat_slip_cnt", 32'd1);
        pop_check(scnt_b);
`endif

        // BER window of 100: 16 invalid sets high_ber, a clean window clears it at the wrap
        push("b_high_ber_t33", 32'd0);
        push("b_high_ber_t34", 32'd1);
        if_b.serdes_rx_hdr = 2'b00;
        for (int t = 20; t <= 34; t++) begin
            tick();
            if (t == 33) pop_check(ber_b);
            if (t == 34) pop_check(ber_b);
        end
        push("b_high_ber_t99", 32'd1);
        push("b_high_ber_t100", 32'd1);
        push("b_high_ber_t199", 32'd1);
        push("b_high_ber_t200", 32'd0);
        push("b_lock_t200", 32'd1);
        if_b.serdes_rx_hdr = 2'b01;
        for (int t = 35; t <= 200; t++) begin
            tick();
            if (t == 99 || t == 100 || t == 199) pop_check(ber_b);
            if (t == 200) begin
                pop_check(ber_b);
                pop_check(lock_b);
            end
        end

        // no lock for two windows -> one-cycle reset request after the 2nd wrap
        rst = 1'b1;
        if_b.serdes_rx_hdr_valid = 1'b0;
        tick();
        rst = 1'b0;
        push("b_reset_req_t100", 32'd0);
        push("b_reset_req_t199", 32'd0);
        push("b_reset_req_t200", 32'd1);
        push("b_reset_req_t201", 32'd0);
        for (int t = 1; t <= 201; t++) begin
            tick();
            if (t == 100 || t == 199 || t == 200 || t == 201) pop_check(if_b.serdes_rx_reset_req);
        end

        // rst during SLIP clears everything and the slip does not resume
        push("b_bitslip_before_rst", 32'd1);
        push("b_outputs_after_rst", 32'd0);
        push("b_bitslip_after_release_1", 32'd0);
        push("b_bitslip_after_release_2", 32'd0);
        if_b.serdes_rx_hdr       = 2'b11;
        if_b.serdes_rx_hdr_valid = 1'b1;
        tick();
        pop_check(if_b.serdes_rx_bitslip);
        rst = 1'b1;
        if_b.serdes_rx_hdr_valid = 1'b0;
        tick();
        pop_check({lock_b, ber_b, if_b.serdes_rx_bitslip, if_b.serdes_rx_reset_req, all_b});
        rst = 1'b0;
        tick();
        pop_check(if_b.serdes_rx_bitslip);
        tick();
        pop_check(if_b.serdes_rx_bitslip);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
